// File: rtl/csr_file_unit.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause plus a 64-bit cycle counter.
// Serves a priority interrupt-controller write/read port, the ex-stage write port and the id-stage read port.
module csr_file_unit #(
    parameter int          CYCLE_W     = 64,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] data_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] data_o,
    input  logic        clint_we_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_data_i,
    input  logic [31:0] clint_raddr_i,
    output logic [31:0] clint_data_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mie_o,
    output logic        global_int_en_o
);

    localparam logic [31:0] A_MSTATUS  = 32'h0000_0300;
    localparam logic [31:0] A_MIE      = 32'h0000_0304;
    localparam logic [31:0] A_MTVEC    = 32'h0000_0305;
    localparam logic [31:0] A_MSCRATCH = 32'h0000_0340;
    localparam logic [31:0] A_MEPC     = 32'h0000_0341;
    localparam logic [31:0] A_MCAUSE   = 32'h0000_0342;
    localparam logic [31:0] A_MCYCLE   = 32'h0000_0B00;
    localparam logic [31:0] A_MCYCLEH  = 32'h0000_0B80;
    localparam logic [31:0] A_CYCLE    = 32'h0000_0C00;
    localparam logic [31:0] A_CYCLEH   = 32'h0000_0C80;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [CYCLE_W-1:0] cycle_inc;

    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_data_m;
    logic        wr_writable;
    logic        wr_hit;

    // The interrupt controller owns the single write slot whenever it asserts its enable.
    always_comb begin
        wr_en   = clint_we_i | we_i;
        wr_addr = clint_we_i ? clint_waddr_i : waddr_i;
        wr_data = clint_we_i ? clint_data_i  : data_i;
        case (wr_addr)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MCYCLE, A_MCYCLEH: wr_writable = 1'b1;
            default:                               wr_writable = 1'b0;
        endcase
        wr_data_m = wr_data;
        if (wr_addr == A_MTVEC || wr_addr == A_MEPC) begin
            wr_data_m[1:0] = 2'b00;
        end
        wr_hit = wr_en & wr_writable;
    end

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        cycle_inc  = cycle_q + 1'b1;
        cycle_d    = cycle_inc;
        if (wr_hit) begin
            case (wr_addr)
                A_MSTATUS:  mstatus_d  = wr_data_m;
                A_MIE:      mie_d      = wr_data_m;
                A_MTVEC:    mtvec_d    = wr_data_m;
                A_MSCRATCH: mscratch_d = wr_data_m;
                A_MEPC:     mepc_d     = wr_data_m;
                A_MCAUSE:   mcause_d   = wr_data_m;
                // The untouched half still advances from the pre-write count.
                A_MCYCLE:   cycle_d[31:0]         = wr_data_m;
                A_MCYCLEH:  cycle_d[CYCLE_W-1:32] = wr_data_m;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            cycle_q    <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            cycle_q    <= cycle_d;
        end
    end

    function automatic logic [31:0] reg_read(input logic [31:0] addr);
        case (addr)
            A_MSTATUS:          reg_read = mstatus_q;
            A_MIE:              reg_read = mie_q;
            A_MTVEC:            reg_read = mtvec_q;
            A_MSCRATCH:         reg_read = mscratch_q;
            A_MEPC:             reg_read = mepc_q;
            A_MCAUSE:           reg_read = mcause_q;
            A_MCYCLE, A_CYCLE:  reg_read = cycle_q[31:0];
            A_MCYCLEH, A_CYCLEH: reg_read = cycle_q[CYCLE_W-1:32];
            default:            reg_read = 32'h0;
        endcase
    endfunction

    // Read-only aliases forward from a write to their machine-mode counterpart.
    function automatic logic fwd_hit(input logic [31:0] addr);
        logic [31:0] canon;
        canon = addr;
        if (addr == A_CYCLE)  canon = A_MCYCLE;
        if (addr == A_CYCLEH) canon = A_MCYCLEH;
        fwd_hit = wr_hit && (canon == wr_addr);
    endfunction

    always_comb begin
        data_o = reg_read(raddr_i);
        if (fwd_hit(raddr_i)) begin
            data_o = wr_data_m;
        end
    end

    always_comb begin
        clint_data_o = reg_read(clint_raddr_i);
        if (fwd_hit(clint_raddr_i)) begin
            clint_data_o = wr_data_m;
        end
    end

    assign csr_mtvec_o     = mtvec_q;
    assign csr_mepc_o      = mepc_q;
    assign csr_mstatus_o   = mstatus_q;
    assign csr_mie_o       = mie_q;
    assign global_int_en_o = mstatus_q[3];

endmodule

// File: doc/csr_file_unit.md
Name: csr_file_unit

Overview:
Machine-mode CSR register file. It is the responder for the interrupt controller's CSR write/read port, and also serves the ex-stage CSR instruction port and the id-stage read port. It holds mstatus, mie, mtvec, mscratch, mepc, mcause and a free-running 64-bit cycle counter. It drives the direct CSR values and the global interrupt enable back to the interrupt controller.

Parameters:
CYCLE_W, 64, width of cycle counter (split into low/high 32-bit CSRs)
RESET_MTVEC, 32'h0000_0000, reset value of mtvec

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
we_i  in  1  ex-stage CSR write enable
waddr_i  in  32  ex-stage CSR write address
data_i  in  32  ex-stage CSR write data
raddr_i  in  32  id-stage CSR read address
data_o  out  32  id-stage CSR read data (combinational)
clint_we_i  in  1  interrupt-controller CSR write enable
clint_waddr_i  in  32  interrupt-controller write address
clint_data_i  in  32  interrupt-controller write data
clint_raddr_i  in  32  interrupt-controller read address
clint_data_o  out  32  interrupt-controller read data (combinational)
csr_mtvec_o  out  32  registered mtvec
csr_mepc_o  out  32  registered mepc
csr_mstatus_o  out  32  registered mstatus
csr_mie_o  out  32  registered mie
global_int_en_o  out  1  mstatus[3] (MIE), registered value

Behaviour:
- Address map: full 32-bit compare; upper 20 bits must be zero. mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, cycle 0xC00 (RO alias of mcycle), cycleh 0xC80 (RO alias of mcycleh).
- Reset (rst=1 at posedge): all CSRs 0 except mtvec=RESET_MTVEC. Cycle counter = 0. Direct outputs follow registers, so they read 0 / RESET_MTVEC. Read ports return the reset values.
- Write arbitration, one write per cycle:
  - clint_we_i=1 wins; the ex write in the same cycle is discarded entirely.
  - Otherwise we_i=1 writes.
  - The write takes effect at the next posedge.
- Write rules:
  - mtvec[1:0] and mepc[1:0] are stored as 0.
  - Writes to 0xC00/0xC80, unmapped addresses, or addresses with nonzero upper bits are ignored, with no side effect.
- Read ports: purely combinational mux. Unmapped address returns 32'h0.
- Forwarding: if a read address equals the winning write address this cycle and the write is to a writable CSR, the read returns the (masked) write data. A discarded ex write is never forwarded.
  - For cycle reads, forwarding applies to mcycle/mcycleh and to the cycle/cycleh aliases of a written half.
  - Without a write, a cycle read returns the current register value, not the incremented one.
- Direct outputs (csr_*_o, global_int_en_o): register values with no forwarding. They update exactly 1 cycle after the write posedge becomes visible, i.e. they reflect the write from the next cycle onward.
- Cycle counter:
  - Out of reset, increments by 1 every cycle.
  - Wraps from 2^64-1 to 0.
  - In a cycle with a winning write to mcycle, the low half takes the write data and the high half takes its incremented-carry value from the pre-write count. Symmetrically, a write to mcycleh replaces the high half and the low half increments normally.
  - Latency: a value V written appears as V in the cycle after the write, then V+1, and so on.
- rst asserted mid-sequence (e.g. during a clint mepc/mstatus/mcause burst): all state returns to reset values at that posedge. No partial write survives.

Test Plan:
- Reset then idle: after rst deasserts, read 0xB00 at cycles 1,2,3 → returns 0,1,2. csr_mtvec_o=RESET_MTVEC, global_int_en_o=0.
- Interrupt-entry burst: clint writes mepc=0x0000_1006, then mstatus=0x0000_0088, then mcause=0x8000_0004 on consecutive cycles → csr_mepc_o=0x0000_1004 one cycle after the first write. global_int_en_o=1 after the second. clint_raddr_i=0x342 returns 0x8000_0004 forwarded in the third cycle.
- Simultaneous writes: clint writes mstatus=0x8, ex writes mstatus=0x0 in the same cycle → mstatus=0x8. data_o for raddr_i=0x300 shows 0x8 in that cycle.
- Ex forwarding/masking: ex writes mtvec=0x0000_2003 while raddr_i=0x305 → data_o=0x0000_2000 in the same cycle, and csr_mtvec_o=0x0000_2000 from the next cycle.
- Counter wrap/write: ex writes mcycleh=0xFFFF_FFFF and mcycle=0xFFFF_FFFE on successive cycles → reads of {0xB80,0xB00} later step ...FFFE, ...FFFF, then 0x0/0x0. A write to 0xC00 changes nothing.
- Unmapped/illegal: write to 0x1341 or 0x7C0 → no CSR changes, and reads of those addresses return 0. Assert rst in the middle of a clint burst → all CSRs are back at reset values the next cycle.
